// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_write_reg,
  input  logic        ex_branch_taken,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        if_id_flush,
  output logic        id_ex_en,
  output logic        id_ex_flush,
  output logic        ex_mem_en,
  output logic        mem_wb_en,
  output logic        mem_wb_flush,
  output logic        mem_error,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_next;
  logic             mem_error_next;
  logic             mem_stall, load_use, branch_flush, lu_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_error <= 1'b0;
    end else begin
      state     <= state_next;
      wait_cnt  <= wait_cnt_next;
      mem_error <= mem_error_next;
    end
  end

  always_comb begin
    state_next     = state;
    wait_cnt_next  = '0;
    mem_error_next = mem_error;

    mem_stall = (state == RUN && dmem_req && !dmem_ready) ||
                (state == MEM_WAIT && !dmem_ready && wait_cnt != WAIT_LAST);
    load_use  = ex_mem_read && (ex_write_reg != 5'd0) &&
                ((ex_write_reg == id_rs) || (id_uses_rt && ex_write_reg == id_rt));
    // EX is frozen during a memory stall, so branch/load-use wait for the release cycle
    branch_flush = !mem_stall && ex_branch_taken;
    lu_stall     = !mem_stall && !ex_branch_taken && load_use;

    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    mem_wb_flush = 1'b0;

    if (!rst) begin
      if (mem_stall) begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_flush = 1'b1;
      end else if (branch_flush) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (lu_stall) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end

    case (state)
      RUN: begin
        if (dmem_req && !dmem_ready) state_next = MEM_WAIT;
      end
      MEM_WAIT: begin
        wait_cnt_next = wait_cnt + 1'b1;
        if (dmem_ready) begin
          state_next = RUN;
        end else if (wait_cnt == WAIT_LAST) begin
          state_next     = RUN;
          mem_error_next = 1'b1;
        end
      end
      default: state_next = RUN;
    endcase
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if ((mem_stall || lu_stall) && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
      if (branch_flush && flush_count != '1) flush_count <= flush_count + 1'b1;
    end
  end
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl.
module tb_pipeline_hazard_ctrl;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_write_reg;
  logic        id_uses_rt, ex_mem_read, ex_branch_taken, dmem_req, dmem_ready;
  logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic        ex_mem_en, mem_wb_en, mem_wb_flush, mem_error;
  logic [31:0] stall_cycles, flush_count;

  int checks = 0;
  int errors = 0;

  // reference model: cycles already stalled on the current memory access
  int          run_len = 0;
  bit          m_err = 0;
  int unsigned m_stall = 0, m_flush = 0;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_write_reg(ex_write_reg), .ex_branch_taken(ex_branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .pc_en(pc_en), .if_id_en(if_id_en),
    .if_id_flush(if_id_flush), .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .mem_wb_flush(mem_wb_flush),
    .mem_error(mem_error), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urt, input logic mr, input logic [4:0] wr, input logic br,
                      input logic rq, input logic rd);
    bit hz, ms, bf, lu;
    logic [7:0] exp_ctrl;
    @(negedge clk);
    rst = r; id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_mem_read = mr;
    ex_write_reg = wr; ex_branch_taken = br; dmem_req = rq; dmem_ready = rd;
    #1;
    hz = mr && wr != 0 && (wr == rs || (urt && wr == rt));
    ms = !rd && ((run_len > 0) ? (run_len < T) : rq);
    bf = !ms && br;
    lu = !ms && !br && hz;
    // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en, mem_wb_flush}
    if (r)       exp_ctrl = 8'b1101_0110;
    else if (ms) exp_ctrl = 8'b0000_0011;
    else if (bf) exp_ctrl = 8'b1111_1110;
    else if (lu) exp_ctrl = 8'b0001_1110;
    else         exp_ctrl = 8'b1101_0110;
    check({tag, ".ctrl"}, {24'd0, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                           ex_mem_en, mem_wb_en, mem_wb_flush}, {24'd0, exp_ctrl});
    check({tag, ".err"}, {31'd0, mem_error}, {31'd0, m_err});
`ifdef HAZARD_PERF_CNT_EN
    check({tag, ".stall_cnt"}, stall_cycles, m_stall);
    check({tag, ".flush_cnt"}, flush_count, m_flush);
`else
    check({tag, ".cnt_tied"}, stall_cycles | flush_count, 32'd0);
`endif
    @(posedge clk);
    if (r) begin
      run_len = 0; m_err = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (ms) run_len++;
      else begin
        if (run_len > 0 && !rd) m_err = 1;
        run_len = 0;
      end
      if ((ms || lu) && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (bf && m_flush != 32'hFFFF_FFFF) m_flush++;
    end
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_mem_read = 0; ex_write_reg = 0;
    ex_branch_taken = 0; dmem_req = 0; dmem_ready = 0;
    repeat (2) @(posedge clk);

    step("in_reset", 1, 5'd8, 5'd0, 0, 1, 5'd8, 0, 1, 0);
    idle("reset_idle");

    step("lu_hit", 0, 5'd8, 5'd3, 0, 1, 5'd8, 0, 0, 0);
    idle("lu_after");
    step("lu_r0", 0, 5'd0, 5'd3, 0, 1, 5'd0, 0, 0, 0);
    step("lu_rt_hit", 0, 5'd4, 5'd9, 1, 1, 5'd9, 0, 0, 0);
    step("lu_rt_unused", 0, 5'd4, 5'd9, 0, 1, 5'd9, 0, 0, 0);
    step("br_lu", 0, 5'd8, 5'd3, 0, 1, 5'd8, 1, 0, 0);

    for (int i = 0; i < 3; i++) step("mem3_wait", 0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1, 0);
    step("mem3_done", 0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1, 1);
    idle("mem3_after");
    step("mem_same_cycle", 0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1, 1);

    for (int i = 0; i < 17; i++) step("timeout", 0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1, 0);
    idle("err_sticky0");
    idle("err_sticky1");

    for (int i = 0; i < 2; i++) step("br_in_wait", 0, 5'd1, 5'd2, 0, 0, 5'd0, 1, 1, 0);
    step("br_release", 0, 5'd1, 5'd2, 0, 0, 5'd0, 1, 1, 1);

    for (int i = 0; i < 2; i++) step("rst_wait", 0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1, 0);
    step("rst_mid_wait", 1, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1, 0);
    idle("post_rst");
    step("post_rst_lu", 0, 5'd8, 5'd3, 0, 1, 5'd8, 0, 0, 0);
    idle("post_rst_idle");

    for (int i = 0; i < 600; i++) begin
      bit slow;
      logic r, rd;
      slow = ((i / 100) % 2) == 1;
      r  = ($urandom_range(0, 79) == 0);
      rd = slow ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 2) != 0);
      step("rand", r, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom),
           1'($urandom), 5'($urandom_range(0, 7)), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 2) == 0), rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline; drives enable and flush of PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves three events: load-use hazard (ID vs EX), taken branch resolved in EX, and multi-cycle data-memory access in MEM (req/ready handshake with timeout).
- Small FSM plus wait counter; all stage-control outputs are combinational from state and inputs.

Parameters:
- MEM_TIMEOUT, 16, max consecutive MEM_WAIT cycles before forced release (>=2)
- CNT_W, 5, width of wait counter (2**CNT_W > MEM_TIMEOUT)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- id_rs  in  5  rs field of instruction in ID
- id_rt  in  5  rt field of instruction in ID
- id_uses_rt  in  1  ID instruction reads rt
- ex_mem_read  in  1  EX instruction is a load
- ex_write_reg  in  5  destination register of EX instruction
- ex_branch_taken  in  1  EX instruction is a taken branch/jump
- dmem_req  in  1  MEM stage is accessing data memory
- dmem_ready  in  1  data memory completes access this cycle
- pc_en  out  1  PC update enable
- if_id_en  out  1  IF/ID capture enable
- if_id_flush  out  1  IF/ID loads bubble
- id_ex_en  out  1  ID/EX capture enable
- id_ex_flush  out  1  ID/EX loads bubble (all ctrl bits 0)
- ex_mem_en  out  1  EX/MEM capture enable
- mem_wb_en  out  1  MEM/WB capture enable
- mem_wb_flush  out  1  MEM/WB loads bubble (RegWrite=0)
- mem_error  out  1  sticky: a memory access timed out
- stall_cycles  out  32  stall-cycle counter (optional feature)
- flush_count  out  32  branch-flush counter (optional feature)

Behaviour:
- States: RUN, MEM_WAIT. Reset: state=RUN, wait_cnt=0, mem_error=0, counters=0. While rst=1: all *_en=1, all *_flush=0.
- Default (RUN, no event): all *_en=1, all *_flush=0.
- mem_stall = (state==RUN && dmem_req && !dmem_ready) || (state==MEM_WAIT && !dmem_ready && wait_cnt!=MEM_TIMEOUT-1).
- mem_stall=1: pc_en=if_id_en=id_ex_en=ex_mem_en=0, mem_wb_en=1, mem_wb_flush=1 (no duplicate WB); branch and load-use outputs suppressed (EX frozen, evaluated again on release).
- RUN -> MEM_WAIT when dmem_req && !dmem_ready; wait_cnt<=0.
- MEM_WAIT: wait_cnt increments each cycle. dmem_ready=1 -> release this cycle (normal RUN outputs incl. branch/load-use evaluation), next state RUN. dmem_ready=0 with wait_cnt==MEM_TIMEOUT-1 -> release this cycle, mem_error<=1, next RUN.
- dmem_ready=1 in the same cycle as dmem_req in RUN: no stall.
- Branch (no mem_stall, ex_branch_taken=1): if_id_flush=1, id_ex_flush=1, pc_en=1; takes priority over load-use.
- Load-use (no mem_stall, no branch): hazard = ex_mem_read && ex_write_reg!=0 && (ex_write_reg==id_rs || (id_uses_rt && ex_write_reg==id_rt)); then pc_en=0, if_id_en=0, id_ex_flush=1; exactly one bubble per load.
- mem_error cleared only by rst.
- rst mid-MEM_WAIT: returns to RUN next edge, wait_cnt=0.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN. Defined: stall_cycles +1 each cycle with mem_stall or load-use stall (saturates at 2^32-1); flush_count +1 each branch flush cycle (saturating); both reset to 0. Undefined: both outputs tied 0, no counter logic.

Test Plan:
- ex_mem_read=1, ex_write_reg=8, id_rs=8 -> one cycle pc_en=0, if_id_en=0, id_ex_flush=1; ex_write_reg=0 same inputs -> no stall.
- ex_branch_taken=1 together with load-use match -> if_id_flush=1, id_ex_flush=1, pc_en=1, if_id_en=1.
- dmem_req=1, dmem_ready low 3 cycles then high -> 3 cycles ex_mem_en=0, mem_wb_flush=1; 4th cycle all enables 1; state RUN after.
- dmem_req=1, dmem_ready=0 forever, MEM_TIMEOUT=16 -> stall exactly 16 cycles, release on 17th, mem_error=1 held until rst.
- ex_branch_taken=1 during MEM_WAIT -> no flush while stalled; flush asserted on release cycle.
- rst asserted in MEM_WAIT -> next cycle all enables 1, mem_error=0; with HAZARD_PERF_CNT_EN, stall_cycles=0 after rst and counts 1 per load-use stall.
